// File: rtl/sync_fifo_dw_pkg.sv
// Shared constants and width helpers for the dual-width FIFO.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package sync_fifo_dw_pkg;

  // Default configuration: 32 x 4-bit writes, 16 x 8-bit reads, FWFT, MSB-first
  localparam int DEF_DIN_WIDTH   = 4;
  localparam int DEF_DOUT_WIDTH  = 8;
  localparam int DEF_WADDR_WIDTH = 5;
  localparam int DEF_FWFT_EN     = 1;
  localparam int DEF_MSB_FIFO    = 1;

  // Which end of the wider word holds the oldest narrow word
  typedef enum logic {
    ORDER_LSB_FIRST = 1'b0,
    ORDER_MSB_FIRST = 1'b1
  } order_e;

  // Storage granule: the narrower of the two port widths
  function automatic int unit_width(input int din_w, input int dout_w);
    return (din_w < dout_w) ? din_w : dout_w;
  endfunction

  // Granules consumed by one write word
  function automatic int wr_units(input int din_w, input int dout_w);
    return din_w / unit_width(din_w, dout_w);
  endfunction

  // Granules consumed by one read word
  function automatic int rd_units(input int din_w, input int dout_w);
    return dout_w / unit_width(din_w, dout_w);
  endfunction

  // log2 of the wide/narrow width ratio
  function automatic int width_ratio_log2(input int din_w, input int dout_w);
    return (din_w > dout_w) ? $clog2(din_w / dout_w) : $clog2(dout_w / din_w);
  endfunction

  // Read-side address width for the same total capacity
  function automatic int raddr_width(input int waddr_w, input int din_w, input int dout_w);
    return (din_w >= dout_w) ? waddr_w + width_ratio_log2(din_w, dout_w)
                             : waddr_w - width_ratio_log2(din_w, dout_w);
  endfunction

  function automatic order_e order_of(input int msb_fifo);
    return (msb_fifo != 0) ? ORDER_MSB_FIRST : ORDER_LSB_FIRST;
  endfunction

endpackage

// File: rtl/sync_fifo_dw_core.sv
// Dual-width FIFO core: granule memory, wrap-bit pointers, registered flags, pack/slice.
// Latency: FWFT head visible the cycle after the completing write; standard mode dout 1 cycle after rd_en.
// Backpressure: writes dropped while full, reads dropped while empty; no error indication.
module sync_fifo_dw_core
  import sync_fifo_dw_pkg::*;
#(
  parameter int DIN_WIDTH   = DEF_DIN_WIDTH,
  parameter int DOUT_WIDTH  = DEF_DOUT_WIDTH,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int FWFT_EN     = DEF_FWFT_EN,
  parameter int MSB_FIFO    = DEF_MSB_FIFO
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DIN_WIDTH-1:0]  i_din,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  output logic [DOUT_WIDTH-1:0] o_dout,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_empty,
  output logic                  o_almost_empty
);

  localparam int     UW       = unit_width(DIN_WIDTH, DOUT_WIDTH);
  localparam int     WR_UNITS = wr_units(DIN_WIDTH, DOUT_WIDTH);
  localparam int     RD_UNITS = rd_units(DIN_WIDTH, DOUT_WIDTH);
  localparam int     UADDR_W  = WADDR_WIDTH + $clog2(WR_UNITS);
  localparam int     DEPTH_U  = 2 ** UADDR_W;
  localparam int     PTR_W    = UADDR_W + 1;
  localparam order_e ORDER    = order_of(MSB_FIFO);

  localparam logic [PTR_W-1:0] WR_STEP  = PTR_W'(WR_UNITS);
  localparam logic [PTR_W-1:0] RD_STEP  = PTR_W'(RD_UNITS);
  // Occupancy at which exactly one write word of space remains
  localparam logic [PTR_W-1:0] FULL_LVL = PTR_W'(DEPTH_U - WR_UNITS);

  logic [UW-1:0]         r_mem [DEPTH_U];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic                  r_full;
  logic                  r_almost_full;
  logic                  r_empty;
  logic                  r_almost_empty;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [PTR_W-1:0]      w_wptr_nxt;
  logic [PTR_W-1:0]      w_rptr_nxt;
  logic [PTR_W-1:0]      w_occ_nxt;
  logic [UADDR_W-1:0]    w_waddr;
  logic [UADDR_W-1:0]    w_raddr;
  logic [UW-1:0]         w_wr_unit [WR_UNITS];
  logic [DOUT_WIDTH-1:0] w_head;

  // Requests are qualified by the flags as they stood before the edge
  assign w_wr_acc   = i_wr_en & ~r_full;
  assign w_rd_acc   = i_rd_en & ~r_empty;
  assign w_wptr_nxt = w_wr_acc ? (r_wptr + WR_STEP) : r_wptr;
  assign w_rptr_nxt = w_rd_acc ? (r_rptr + RD_STEP) : r_rptr;
  assign w_occ_nxt  = w_wptr_nxt - w_rptr_nxt;
  assign w_waddr    = r_wptr[UADDR_W-1:0];
  assign w_raddr    = r_rptr[UADDR_W-1:0];

  // Cut the write word into granules in the order they will be read out
  always_comb begin
    for (int k = 0; k < WR_UNITS; k++) begin
      if (ORDER == ORDER_MSB_FIRST) w_wr_unit[k] = i_din[DIN_WIDTH-1-k*UW -: UW];
      else                          w_wr_unit[k] = i_din[k*UW +: UW];
    end
  end

  // Store all granules of an accepted write word; pointers stay word-aligned so no split wrap
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) begin
      for (int k = 0; k < WR_UNITS; k++) begin
        r_mem[w_waddr + UADDR_W'(k)] <= w_wr_unit[k];
      end
    end
  end

  // Assemble the read word at the head, oldest granule at the selected end
  always_comb begin
    w_head = '0;
    for (int k = 0; k < RD_UNITS; k++) begin
      if (ORDER == ORDER_MSB_FIRST) w_head[DOUT_WIDTH-1-k*UW -: UW] = r_mem[w_raddr + UADDR_W'(k)];
      else                          w_head[k*UW +: UW]              = r_mem[w_raddr + UADDR_W'(k)];
    end
  end

  // Pointers and flags; flags sit at "no space / no data" while reset is held
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr         <= '0;
      r_rptr         <= '0;
      r_full         <= 1'b1;
      r_almost_full  <= 1'b1;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      r_wptr         <= w_wptr_nxt;
      r_rptr         <= w_rptr_nxt;
      r_full         <= (w_occ_nxt >  FULL_LVL);
      r_almost_full  <= (w_occ_nxt >= FULL_LVL);
      r_empty        <= (w_occ_nxt <  RD_STEP);
      r_almost_empty <= (w_occ_nxt <= RD_STEP);
    end
  end

  generate
    if (FWFT_EN != 0) begin : g_fwft
      // Head word shown directly; forced to zero while no complete word exists
      assign o_dout = r_empty ? '0 : w_head;
    end else begin : g_std
      logic [DOUT_WIDTH-1:0] r_dout;
      // Output register loads the head only on an accepted read
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_dout <= '0;
        else if (w_rd_acc) r_dout <= w_head;
      end
      assign o_dout = r_dout;
    end
  endgenerate

  assign o_full         = r_full;
  assign o_almost_full  = r_almost_full;
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;

endmodule

// File: rtl/sync_fifo_dw_vendor.sv
// Native common-clock FIFO-generator stand-in with asymmetric ports (word-addressed flat storage).
// Latency: FWFT head visible the cycle after the completing write; standard mode dout 1 cycle after rd_en.
// Backpressure: writes dropped while full, reads dropped while empty.
module sync_fifo_dw_vendor
  import sync_fifo_dw_pkg::*;
#(
  parameter int DIN_WIDTH   = DEF_DIN_WIDTH,
  parameter int DOUT_WIDTH  = DEF_DOUT_WIDTH,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int RADDR_WIDTH = DEF_WADDR_WIDTH - 1,
  parameter int FWFT_EN     = DEF_FWFT_EN,
  parameter int MSB_FIFO    = DEF_MSB_FIFO
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DIN_WIDTH-1:0]  i_din,
  input  logic                  i_wr_en,
  input  logic                  i_rd_en,
  output logic [DOUT_WIDTH-1:0] o_dout,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic                  o_empty,
  output logic                  o_almost_empty
);

  localparam int     TOTAL_BITS = (2 ** WADDR_WIDTH) * DIN_WIDTH;
  localparam int     UW         = unit_width(DIN_WIDTH, DOUT_WIDTH);
  localparam int     DEPTH_U    = TOTAL_BITS / UW;
  localparam int     CNT_W      = $clog2(DEPTH_U) + 1;
  localparam order_e ORDER      = order_of(MSB_FIFO);

  localparam logic [CNT_W-1:0] WR_CNT   = CNT_W'(wr_units(DIN_WIDTH, DOUT_WIDTH));
  localparam logic [CNT_W-1:0] RD_CNT   = CNT_W'(rd_units(DIN_WIDTH, DOUT_WIDTH));
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH_U - wr_units(DIN_WIDTH, DOUT_WIDTH));

  logic [TOTAL_BITS-1:0]  r_bits;
  logic [WADDR_WIDTH-1:0] r_waddr;
  logic [RADDR_WIDTH-1:0] r_raddr;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_full;
  logic                   r_almost_full;
  logic                   r_empty;
  logic                   r_almost_empty;

  logic                   w_wr_acc;
  logic                   w_rd_acc;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [DOUT_WIDTH-1:0]  w_head;

  assign w_wr_acc  = i_wr_en & ~r_full;
  assign w_rd_acc  = i_rd_en & ~r_empty;
  assign w_cnt_nxt = r_cnt + (w_wr_acc ? WR_CNT : '0) - (w_rd_acc ? RD_CNT : '0);

  // Whole write words land at their write address unchanged
  always_ff @(posedge i_clk) begin
    if (w_wr_acc) r_bits[int'(r_waddr)*DIN_WIDTH +: DIN_WIDTH] <= i_din;
  end

  generate
    if (DIN_WIDTH >= DOUT_WIDTH) begin : g_slice
      localparam int R = DIN_WIDTH / DOUT_WIDTH;
      logic [DIN_WIDTH-1:0] w_word;
      // Pick the write word holding this read address, then the slice within it
      always_comb begin
        int wi;
        int si;
        wi     = int'(r_raddr) / R;
        si     = int'(r_raddr) % R;
        w_word = r_bits[wi*DIN_WIDTH +: DIN_WIDTH];
        if (ORDER == ORDER_MSB_FIRST) w_head = w_word[DIN_WIDTH-1-si*DOUT_WIDTH -: DOUT_WIDTH];
        else                          w_head = w_word[si*DOUT_WIDTH +: DOUT_WIDTH];
      end
    end else begin : g_pack
      localparam int R = DOUT_WIDTH / DIN_WIDTH;
      // Gather the R consecutive write words behind this read address
      always_comb begin
        w_head = '0;
        for (int j = 0; j < R; j++) begin
          if (ORDER == ORDER_MSB_FIRST)
            w_head[DOUT_WIDTH-1-j*DIN_WIDTH -: DIN_WIDTH] = r_bits[(int'(r_raddr)*R + j)*DIN_WIDTH +: DIN_WIDTH];
          else
            w_head[j*DIN_WIDTH +: DIN_WIDTH] = r_bits[(int'(r_raddr)*R + j)*DIN_WIDTH +: DIN_WIDTH];
        end
      end
    end
  endgenerate

  // Addresses, occupancy count and flags
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_waddr        <= '0;
      r_raddr        <= '0;
      r_cnt          <= '0;
      r_full         <= 1'b1;
      r_almost_full  <= 1'b1;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_acc) r_waddr <= r_waddr + 1'b1;
      if (w_rd_acc) r_raddr <= r_raddr + 1'b1;
      r_cnt          <= w_cnt_nxt;
      r_full         <= (w_cnt_nxt >  FULL_LVL);
      r_almost_full  <= (w_cnt_nxt >= FULL_LVL);
      r_empty        <= (w_cnt_nxt <  RD_CNT);
      r_almost_empty <= (w_cnt_nxt <= RD_CNT);
    end
  end

  generate
    if (FWFT_EN != 0) begin : g_fwft
      assign o_dout = r_empty ? '0 : w_head;
    end else begin : g_std
      logic [DOUT_WIDTH-1:0] r_dout;
      // Registered read data, loaded on accepted reads only
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         r_dout <= '0;
        else if (w_rd_acc) r_dout <= w_head;
      end
      assign o_dout = r_dout;
    end
  endgenerate

  assign o_full         = r_full;
  assign o_almost_full  = r_almost_full;
  assign o_empty        = r_empty;
  assign o_almost_empty = r_almost_empty;

endmodule

// File: rtl/my_sync_fifo_top.sv
// Dual-width FIFO top: custom core plus an identically configured vendor-style FIFO side by side.
// Latency: as the core (FWFT combinational head, or 1-cycle registered read).
// Backpressure: full/empty flags; requests against them are dropped.
module my_sync_fifo_top
  import sync_fifo_dw_pkg::*;
#(
  parameter int DIN_WIDTH   = DEF_DIN_WIDTH,
  parameter int DOUT_WIDTH  = DEF_DOUT_WIDTH,
  parameter int WADDR_WIDTH = DEF_WADDR_WIDTH,
  parameter int FWFT_EN     = DEF_FWFT_EN,
  parameter int MSB_FIFO    = DEF_MSB_FIFO
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIN_WIDTH-1:0]  din,
  input  logic                  wr_en,
  output logic                  full,
  output logic                  almost_full,
  output logic [DOUT_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [DOUT_WIDTH-1:0] vivado_fifo_dout,
  output logic                  vivado_fifo_full,
  output logic                  vivado_fifo_empty,
  output logic                  vivado_fifo_almost_full,
  output logic                  vivado_fifo_almost_empty
);

  localparam int RADDR_WIDTH = raddr_width(WADDR_WIDTH, DIN_WIDTH, DOUT_WIDTH);

  sync_fifo_dw_core #(
    .DIN_WIDTH   (DIN_WIDTH),
    .DOUT_WIDTH  (DOUT_WIDTH),
    .WADDR_WIDTH (WADDR_WIDTH),
    .FWFT_EN     (FWFT_EN),
    .MSB_FIFO    (MSB_FIFO)
  ) u_core (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_din          (din),
    .i_wr_en        (wr_en),
    .i_rd_en        (rd_en),
    .o_dout         (dout),
    .o_full         (full),
    .o_almost_full  (almost_full),
    .o_empty        (empty),
    .o_almost_empty (almost_empty)
  );

  // Reference FIFO fed by the same requests; outputs passed through untouched
  sync_fifo_dw_vendor #(
    .DIN_WIDTH   (DIN_WIDTH),
    .DOUT_WIDTH  (DOUT_WIDTH),
    .WADDR_WIDTH (WADDR_WIDTH),
    .RADDR_WIDTH (RADDR_WIDTH),
    .FWFT_EN     (FWFT_EN),
    .MSB_FIFO    (MSB_FIFO)
  ) u_vivado_fifo (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_din          (din),
    .i_wr_en        (wr_en),
    .i_rd_en        (rd_en),
    .o_dout         (vivado_fifo_dout),
    .o_full         (vivado_fifo_full),
    .o_almost_full  (vivado_fifo_almost_full),
    .o_empty        (vivado_fifo_empty),
    .o_almost_empty (vivado_fifo_almost_empty)
  );

endmodule

// File: tb/tb_my_sync_fifo_top.sv
// Bench for the dual-width FIFO: FWFT/MSB-first and standard/LSB-first instances on shared stimulus.
// Expected bytes come from a nibble-queue model and are popped by a decoupled negedge monitor.
module tb_my_sync_fifo_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [3:0] din = 4'h0;

  logic [7:0] a_dout, a_vdout, b_dout, b_vdout;
  logic a_full, a_af, a_empty, a_ae, a_vfull, a_vaf, a_vempty, a_vae;
  logic b_full, b_af, b_empty, b_ae, b_vfull, b_vaf, b_vempty, b_vae;

  always #5 clk = ~clk;

  my_sync_fifo_top #(.DIN_WIDTH(4), .DOUT_WIDTH(8), .WADDR_WIDTH(5), .FWFT_EN(1), .MSB_FIFO(1)) dut_a (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(a_full), .almost_full(a_af),
    .dout(a_dout), .rd_en(rd_en), .empty(a_empty), .almost_empty(a_ae),
    .vivado_fifo_dout(a_vdout), .vivado_fifo_full(a_vfull), .vivado_fifo_empty(a_vempty),
    .vivado_fifo_almost_full(a_vaf), .vivado_fifo_almost_empty(a_vae)
  );

  my_sync_fifo_top #(.DIN_WIDTH(4), .DOUT_WIDTH(8), .WADDR_WIDTH(5), .FWFT_EN(0), .MSB_FIFO(0)) dut_b (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(b_full), .almost_full(b_af),
    .dout(b_dout), .rd_en(rd_en), .empty(b_empty), .almost_empty(b_ae),
    .vivado_fifo_dout(b_vdout), .vivado_fifo_full(b_vfull), .vivado_fifo_empty(b_vempty),
    .vivado_fifo_almost_full(b_vaf), .vivado_fifo_almost_empty(b_vae)
  );

  int n_chk = 0;
  int n_err = 0;

  bit [3:0] mq[$];      // nibbles currently held, oldest first
  bit [7:0] exp_a[$];   // bytes owed by the MSB-first instance
  bit [7:0] exp_b[$];   // bytes owed by the LSB-first instance
  bit e_full = 1'b1, e_af = 1'b1, e_empty = 1'b1, e_ae = 1'b1;
  bit flags_rst = 1'b1;
  bit chk_en = 1'b0;
  bit pend_b = 1'b0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from its own occupancy
  task automatic step(input bit r, input bit w, input bit rd, input logic [3:0] d);
    bit wacc, racc;
    bit [3:0] n0, n1;
    @(posedge clk);
    #2;
    chk_en = 1'b1;
    if (flags_rst || r) begin
      e_full = 1'b1; e_af = 1'b1; e_empty = 1'b1; e_ae = 1'b1;
    end else begin
      e_full  = (mq.size() >= 32);
      e_af    = (mq.size() >= 31);
      e_empty = (mq.size() < 2);
      e_ae    = (mq.size() <= 2);
    end
    rst = r; wr_en = w; rd_en = rd; din = d;
    if (r) begin
      mq.delete();
    end else begin
      racc = rd && !e_empty;
      wacc = w && !e_full;
      if (racc) begin
        n0 = mq.pop_front();
        n1 = mq.pop_front();
        exp_a.push_back({n0, n1});
        exp_b.push_back({n1, n0});
      end
      if (wacc) mq.push_back(d);
    end
    flags_rst = r;
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
  endtask

  // Monitor: flags every cycle, data whenever an instance presents a popped word
  always @(negedge clk) begin
    if (chk_en) begin
      chk("full_a", {7'd0, a_full}, {7'd0, e_full});
      chk("afull_a", {7'd0, a_af}, {7'd0, e_af});
      chk("empty_a", {7'd0, a_empty}, {7'd0, e_empty});
      chk("aempty_a", {7'd0, a_ae}, {7'd0, e_ae});
      chk("vfull_a", {7'd0, a_vfull}, {7'd0, e_full});
      chk("vafull_a", {7'd0, a_vaf}, {7'd0, e_af});
      chk("vempty_a", {7'd0, a_vempty}, {7'd0, e_empty});
      chk("vaempty_a", {7'd0, a_vae}, {7'd0, e_ae});
      chk("full_b", {7'd0, b_full}, {7'd0, e_full});
      chk("afull_b", {7'd0, b_af}, {7'd0, e_af});
      chk("empty_b", {7'd0, b_empty}, {7'd0, e_empty});
      chk("aempty_b", {7'd0, b_ae}, {7'd0, e_ae});
      chk("vfull_b", {7'd0, b_vfull}, {7'd0, e_full});
      chk("vafull_b", {7'd0, b_vaf}, {7'd0, e_af});
      chk("vempty_b", {7'd0, b_vempty}, {7'd0, e_empty});
      chk("vaempty_b", {7'd0, b_vae}, {7'd0, e_ae});
      if (rst) begin
        chk("rst_dout_a", a_dout, 8'h00);
        chk("rst_vdout_a", a_vdout, 8'h00);
        chk("rst_dout_b", b_dout, 8'h00);
        chk("rst_vdout_b", b_vdout, 8'h00);
        pend_b = 1'b0;
      end else begin
        if (pend_b) begin
          if (exp_b.size() == 0) begin
            chk("pop_b_unexpected", 8'h01, 8'h00);
          end else begin
            bit [7:0] x;
            x = exp_b.pop_front();
            chk("dout_b", b_dout, x);
            chk("vdout_b", b_vdout, x);
          end
        end
        if (rd_en && !a_empty) begin
          if (exp_a.size() == 0) begin
            chk("pop_a_unexpected", 8'h01, 8'h00);
          end else begin
            bit [7:0] y;
            y = exp_a.pop_front();
            chk("dout_a", a_dout, y);
            chk("vdout_a", a_vdout, y);
          end
        end
        pend_b = rd_en && !b_empty;
      end
    end
  end

  initial begin
    // Reset held two cycles, release, then one more cycle for flags to clear
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Pack two nibbles into one byte, pop it
    step(1'b0, 1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 1'b0, 4'h1);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Variant pattern: 0xA then 0xB
    step(1'b0, 1'b1, 1'b0, 4'hA);
    step(1'b0, 1'b1, 1'b0, 4'hB);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Fill past capacity with an incrementing sequence; the last two are dropped
    for (int i = 0; i < 34; i++) step(1'b0, 1'b1, 1'b0, 4'(i + 2));
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Drain everything plus one read on empty
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Concurrent write and read starting from empty
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'b1, 4'(i + 3));
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Reset while data is held
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 4'(i * 5));
    do_reset();
    step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);

    // Random traffic alternating write-heavy and read-heavy bursts
    for (int i = 0; i < 1600; i++) begin
      bit w, rd, hi;
      hi = ((i / 200) % 2) == 0;
      w  = $urandom_range(0, 99) < (hi ? 80 : 30);
      rd = $urandom_range(0, 99) < (hi ? 30 : 80);
      step(1'b0, w, rd, 4'($urandom));
      if ((i % 600) == 599) do_reset();
    end

    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b1, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0);
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    chk("leftover_a", 8'(exp_a.size()), 8'h00);
    chk("leftover_b", 8'(exp_b.size()), 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
